// File: rtl/dl11_uart_if.sv
// Register bus between the Unibus mapper and the DL11 console line unit.
// The mapper drives the master side; dl11_uart is the slave.
interface dl11_uart_if;
    logic        uartreq;
    logic [2:0]  uartaddr;
    logic        uartwr;
    logic [15:0] uartwdata;
    logic        uartack;
    logic [15:0] uartrdata;

    modport master (output uartreq, uartaddr, uartwr, uartwdata,
                    input  uartack, uartrdata);
    modport slave  (input  uartreq, uartaddr, uartwr, uartwdata,
                    output uartack, uartrdata);
endinterface

// File: rtl/dl11_uart.sv
// DL11-style console line unit: RCSR/RBUF/XCSR/XBUF registers, 8N1 receiver and transmitter.
// Optional DL11_LOOPBACK_EN adds XCSR.MAINT, which feeds txd back into the receiver.
module dl11_uart #(
    parameter int CLKDIV = 434
) (
    input  logic        clk,
    input  logic        rstn,
    dl11_uart_if.slave  bus,
    input  logic        rxd,
    output logic        txd,
    output logic        rxirq,
    output logic        txirq
);
    localparam logic [15:0] FULL = 16'(CLKDIV - 1);
    localparam logic [15:0] HALF = 16'(CLKDIV / 2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic        rx_done, rx_ie, rx_or, rx_fe;
    logic [7:0]  rx_data, rx_shift;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_in, rx_s0, rx_s1, rx_last;

    logic        tx_ready, tx_ie, maint;
    logic [7:0]  tx_shift;
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;

    logic [1:0]  sel;
    logic        rd, wr, rbuf_rd, xbuf_wr;
    logic [15:0] rdata_mux;
    logic        unused_bits;

`ifdef DL11_LOOPBACK_EN
    assign rx_in = maint ? txd : rxd;
`else
    assign rx_in = rxd;
    assign maint = 1'b0;
`endif

    assign sel     = bus.uartaddr[2:1];
    assign rd      = bus.uartreq & ~bus.uartwr;
    assign wr      = bus.uartreq &  bus.uartwr;
    assign rbuf_rd = rd & (sel == 2'd1);
    assign xbuf_wr = wr & (sel == 2'd3) & tx_ready;

    assign rxirq = rx_done & rx_ie;
    assign txirq = tx_ready & tx_ie;

    assign unused_bits = &{1'b0, bus.uartaddr[0], bus.uartwdata};

    always_comb begin
        rdata_mux = 16'h0000;
        case (sel)
            2'd0:    rdata_mux = {8'h00, rx_done, rx_ie, 6'h00};
            2'd1:    rdata_mux = {rx_or | rx_fe, rx_or, rx_fe, 5'h00, rx_data};
            2'd2:    rdata_mux = {8'h00, tx_ready, tx_ie, 3'h0, maint, 2'h0};
            default: rdata_mux = 16'h0000;
        endcase
    end

    // NOTE: every register below is written with <= so all state moves together on the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.uartack   <= 1'b0;
            bus.uartrdata <= 16'h0000;
            rx_ie         <= 1'b0;
            tx_ie         <= 1'b0;
        end else begin
            bus.uartack   <= bus.uartreq;
            bus.uartrdata <= rd ? rdata_mux : 16'h0000;
            if (wr && sel == 2'd0) rx_ie <= bus.uartwdata[6];
            if (wr && sel == 2'd2) tx_ie <= bus.uartwdata[6];
        end
    end

`ifdef DL11_LOOPBACK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  maint <= 1'b0;
        else if (wr && sel == 2'd2) maint <= bus.uartwdata[2];
    end
`endif

    // Receiver; a completion on the same edge as an RBUF read wins, so DONE stays set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s0 <= 1'b1; rx_s1 <= 1'b1; rx_last <= 1'b1;
            rx_state <= ST_IDLE; rx_cnt <= 16'h0; rx_bit <= 3'd0; rx_shift <= 8'h00;
            rx_done <= 1'b0; rx_or <= 1'b0; rx_fe <= 1'b0; rx_data <= 8'h00;
        end else begin
            rx_s0   <= rx_in;
            rx_s1   <= rx_s0;
            rx_last <= rx_s1;
            if (rbuf_rd) rx_done <= 1'b0;
            case (rx_state)
                ST_IDLE: if (rx_last && !rx_s1) begin
                    rx_state <= ST_START;
                    rx_cnt   <= HALF;
                end
                ST_START: if (rx_cnt != 16'h0) rx_cnt <= rx_cnt - 16'h1;
                    else if (rx_s1) rx_state <= ST_IDLE;
                    else begin
                        rx_state <= ST_DATA;
                        rx_cnt   <= FULL;
                        rx_bit   <= 3'd0;
                    end
                ST_DATA: if (rx_cnt != 16'h0) rx_cnt <= rx_cnt - 16'h1;
                    else begin
                        rx_shift <= {rx_s1, rx_shift[7:1]};
                        rx_cnt   <= FULL;
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end
                default: if (rx_cnt != 16'h0) rx_cnt <= rx_cnt - 16'h1;
                    else begin
                        rx_data  <= rx_shift;
                        rx_fe    <= ~rx_s1;
                        rx_or    <= rx_done;
                        rx_done  <= 1'b1;
                        rx_bit   <= 3'd0;
                        rx_state <= ST_IDLE;
                    end
            endcase
        end
    end

    // NOTE: txd is a reset flop, so the line returns to idle the instant rstn falls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txd <= 1'b1; tx_ready <= 1'b1;
            tx_state <= ST_IDLE; tx_cnt <= 16'h0; tx_bit <= 3'd0; tx_shift <= 8'h00;
        end else begin
            case (tx_state)
                ST_IDLE: if (xbuf_wr) begin
                    tx_shift <= bus.uartwdata[7:0];
                    txd      <= 1'b0;
                    tx_cnt   <= FULL;
                    tx_ready <= 1'b0;
                    tx_state <= ST_START;
                end
                ST_START: if (tx_cnt != 16'h0) tx_cnt <= tx_cnt - 16'h1;
                    else begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_cnt   <= FULL;
                        tx_bit   <= 3'd0;
                        tx_state <= ST_DATA;
                    end
                ST_DATA: if (tx_cnt != 16'h0) tx_cnt <= tx_cnt - 16'h1;
                    else begin
                        tx_cnt <= FULL;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                default: if (tx_cnt != 16'h0) tx_cnt <= tx_cnt - 16'h1;
                    else begin
                        tx_ready <= 1'b1;
                        tx_bit   <= 3'd0;
                        tx_state <= ST_IDLE;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_dl11_uart.sv
// Directed-plus-random bench for dl11_uart at CLKDIV = 8: register map, TX frames,
// RX frames against a byte-level line model, overrun/framing errors, glitches, reset.
module tb_dl11_uart;
    localparam int CLKDIV = 8;
    localparam int HIST   = 16384;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rxd = 1'b1;
    logic txd, rxirq, txirq;

    dl11_uart_if bus ();

    dl11_uart #(.CLKDIV(CLKDIV)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .rxd   (rxd),
        .txd   (txd),
        .rxirq (rxirq),
        .txirq (txirq)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; histories hold the value seen during the cycle after edge cyc.
    int   cyc = 0;
    logic txd_hist   [HIST];
    logic txirq_hist [HIST];
    logic rxirq_hist [HIST];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < HIST) begin
        txd_hist[cyc]   = txd;
        txirq_hist[cyc] = txirq;
        rxirq_hist[cyc] = rxirq;
    end

    int tests = 0;
    int fails = 0;

    // Receive-side model: what RBUF/RCSR must hold after whole frames and reads.
    logic       m_done = 1'b0, m_or = 1'b0, m_fe = 1'b0;
    logic [7:0] m_data = 8'h00;

    function automatic logic [15:0] m_rbuf();
        return {m_or | m_fe, m_or, m_fe, 5'h00, m_data};
    endfunction

    task automatic m_frame(input logic [7:0] data, input logic stop);
        m_or   = m_done;
        m_fe   = ~stop;
        m_data = data;
        m_done = 1'b1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All stimulus runs at 1 time unit after a rising edge; the access is taken on the next edge.
    task automatic access(input logic w, input logic [2:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata);
        bus.uartreq   = 1'b1;
        bus.uartaddr  = addr;
        bus.uartwr    = w;
        bus.uartwdata = wdata;
        @(posedge clk); #1;
        bus.uartreq = 1'b0;
        bus.uartwr  = 1'b0;
        check("ack", 16'(bus.uartack), 16'd1);
        rdata = bus.uartrdata;
    endtask

    task automatic rd_check(input logic [2:0] addr, input string tag, input logic [15:0] exp);
        logic [15:0] d;
        access(1'b0, addr, 16'h0000, d);
        check(tag, d, exp);
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [15:0] data);
        logic [15:0] d;
        access(1'b1, addr, data, d);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        logic [9:0] f;
        f = {stop, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            repeat (CLKDIV) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    // Frame starts on edge a: bit k must hold for cycles a+k*CLKDIV .. a+k*CLKDIV+CLKDIV-1.
    task automatic tx_frame_check(input int a, input logic [7:0] data, input string tag,
                                  input logic ie);
        logic [9:0] f;
        logic [CLKDIV-1:0] obs;
        f = {1'b1, data, 1'b0};
        check({tag, " idle before"}, 16'(txd_hist[a-1]), 16'd1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CLKDIV; j++) obs[j] = txd_hist[a + k*CLKDIV + j];
            check($sformatf("%s bit%0d", tag, k), 16'(obs), 16'({CLKDIV{f[k]}}));
        end
        if (ie)
            check({tag, " txirq rise"}, 16'({txirq_hist[a + 10*CLKDIV - 1], txirq_hist[a + 10*CLKDIV]}),
                  16'b01);
    endtask

    initial begin
        int a, e0;
        logic [7:0] b;
        logic stop, do_read;
        logic [15:0] old;

        bus.uartreq = 1'b0; bus.uartaddr = 3'd0; bus.uartwr = 1'b0; bus.uartwdata = 16'h0;

        // Reset state
        #12;
        check("rst txd", 16'(txd), 16'd1);
        check("rst rxirq", 16'(rxirq), 16'd0);
        check("rst txirq", 16'(txirq), 16'd0);
        check("rst ack", 16'(bus.uartack), 16'd0);
        check("rst rdata", bus.uartrdata, 16'h0000);
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_cycles(2);

        rd_check(3'd4, "XCSR reset", 16'h0080);
        rd_check(3'd5, "XCSR odd addr", 16'h0080);
        rd_check(3'd0, "RCSR reset", 16'h0000);
        rd_check(3'd2, "RBUF reset", 16'h0000);
        rd_check(3'd6, "XBUF reads 0", 16'h0000);

        // MAINT exists only with the loopback build
        wr_reg(3'd4, 16'h0044);
`ifdef DL11_LOOPBACK_EN
        rd_check(3'd4, "XCSR maint rw", 16'h00C4);
`else
        rd_check(3'd4, "XCSR maint ignored", 16'h00C0);
`endif
        wr_reg(3'd4, 16'h0040);
        rd_check(3'd4, "XCSR ie", 16'h00C0);
        check("txirq idle ie", 16'(txirq), 16'd1);

        // Directed transmit of 0xA5 with a mid-frame write that must be ignored
        wr_reg(3'd6, 16'h00A5);
        a = cyc;
        check("txirq busy", 16'(txirq), 16'd0);
        rd_check(3'd4, "XCSR busy", 16'h0040);
        wait_cycles(20);
        wr_reg(3'd6, 16'h0011);
        rd_check(3'd4, "XCSR still busy", 16'h0040);
        wait_cycles(10*CLKDIV);
        tx_frame_check(a, 8'hA5, "txA5", 1'b1);
        rd_check(3'd4, "XCSR done", 16'h00C0);

        // Random transmit bytes
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            wr_reg(3'd6, {8'($urandom), b});
            a = cyc;
            wait_cycles(10*CLKDIV + 2);
            tx_frame_check(a, b, $sformatf("txrnd%0d", i), 1'b1);
        end

        // Directed receive of 0x3C with interrupts enabled
        wr_reg(3'd0, 16'h0040);
        e0 = cyc + 1;
        send_frame(8'h3C, 1'b1);
        m_frame(8'h3C, 1'b1);
        rd_check(3'd0, "RCSR done", 16'h00C0);
        check("rxirq set", 16'(rxirq), 16'd1);
        check("rx latency", 16'({rxirq_hist[e0 + 76], rxirq_hist[e0 + 79]}), 16'b01);
        wr_reg(3'd2, 16'hFFFF);
        rd_check(3'd2, "RBUF 3C", 16'h003C);
        m_done = 1'b0;
        rd_check(3'd0, "RCSR cleared", 16'h0040);
        check("rxirq clear", 16'(rxirq), 16'd0);

        // Overrun, then framing error
        send_frame(8'h11, 1'b1); m_frame(8'h11, 1'b1);
        wait_cycles(3);
        send_frame(8'h22, 1'b1); m_frame(8'h22, 1'b1);
        rd_check(3'd2, "RBUF overrun", 16'hC022);
        m_done = 1'b0;
        send_frame(8'h55, 1'b0); m_frame(8'h55, 1'b0);
        rd_check(3'd2, "RBUF framing", m_rbuf());
        m_done = 1'b0;

        // Short low glitch must be rejected as a false start
        rxd = 1'b0;
        wait_cycles(2);
        rxd = 1'b1;
        wait_cycles(100);
        rd_check(3'd0, "RCSR after glitch", 16'h0040);
        check("rxirq glitch", 16'(rxirq), 16'd0);

        // Random receive traffic with optional reads
        for (int i = 0; i < 8; i++) begin
            b       = 8'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            do_read = 1'($urandom_range(0, 1));
            send_frame(b, stop);
            m_frame(b, stop);
            rd_check(3'd0, $sformatf("rxrnd%0d RCSR", i), {8'h00, m_done, 1'b1, 6'h00});
            if (do_read) begin
                rd_check(3'd2, $sformatf("rxrnd%0d RBUF", i), m_rbuf());
                m_done = 1'b0;
            end
            wait_cycles($urandom_range(0, 5));
        end

        // RBUF read on the same edge as a completion: old data returned, DONE stays set
        send_frame(8'h77, 1'b1); m_frame(8'h77, 1'b1);
        old = m_rbuf();
        e0 = cyc + 1;
        fork
            send_frame(8'h99, 1'b1);
            begin
                while (cyc != e0 + 77) begin @(posedge clk); #1; end
                rd_check(3'd2, "RBUF collide old", old);
            end
        join
        m_frame(8'h99, 1'b1);
        rd_check(3'd0, "RCSR collide", 16'h00C0);
        rd_check(3'd2, "RBUF collide new", m_rbuf());
        m_done = 1'b0;

        // Reset in the middle of a transmitted data bit
        wr_reg(3'd6, 16'h003C);
        a = cyc;
        while (cyc != a + 3*CLKDIV + CLKDIV/2) begin @(posedge clk); #1; end
        #2;
        rstn = 1'b0;
        #1;
        check("mid rst txd", 16'(txd), 16'd1);
        check("mid rst txirq", 16'(txirq), 16'd0);
        check("mid rst rxirq", 16'(rxirq), 16'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        m_done = 1'b0; m_or = 1'b0; m_fe = 1'b0; m_data = 8'h00;
        rd_check(3'd4, "XCSR after rst", 16'h0080);
        rd_check(3'd0, "RCSR after rst", 16'h0000);
        rd_check(3'd2, "RBUF after rst", 16'h0000);
        wait_cycles(20);
        check("txd idle after rst", 16'(txd), 16'd1);

`ifdef DL11_LOOPBACK_EN
        wr_reg(3'd4, 16'h0004);
        wr_reg(3'd6, 16'h005A);
        wait_cycles(10*CLKDIV + 10);
        rd_check(3'd2, "RBUF loopback", 16'h005A);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
